// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: stream FIFO controller around an external 1W / 1 async-read RAM.
// Owns the pointers, full/empty tracking and both valid/ready handshakes.
// Optional feature macro: RAM_FIFO_CTRL_OUTPUT_REG_EN adds a one-entry registered
// output stage (pop side fully registered, capacity 2^DEPTH_LOG2 + 1).
module ram_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [WIDTH-1:0]      push_payload,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [WIDTH-1:0]      pop_payload,
  output logic [DEPTH_LOG2+1:0] occupancy,
  output logic                  ram_wr_en,
  output logic [DEPTH_LOG2-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic [DEPTH_LOG2-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ram_count;
  logic          ram_empty;
  logic          ram_full;
  logic          push_fire;
  logic          pop_fire;
  logic          deq;

  // The MSB of each pointer is a wrap flag, so equal low bits mean either empty or full.
  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign ram_count = wr_ptr - rd_ptr;

  assign push_ready = !ram_full && !flush;
  assign push_fire  = push_valid && push_ready;

  assign ram_wr_en   = push_fire;
  assign ram_wr_addr = wr_ptr[DEPTH_LOG2-1:0];
  assign ram_wr_data = push_payload;
  assign ram_rd_addr = rd_ptr[DEPTH_LOG2-1:0];

  // Pointer update: flush rewinds both pointers, otherwise advance on push and dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq)       rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef RAM_FIFO_CTRL_OUTPUT_REG_EN
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  assign pop_fire = out_valid && pop_ready && !flush;
  // Refill the stage whenever it is empty or being drained this cycle.
  assign deq      = !ram_empty && (!out_valid || pop_fire) && !flush;

  // Output stage: loads from the RAM on dequeue, empties on a pop with nothing behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (deq) begin
      out_valid <= 1'b1;
      out_data  <= ram_rd_data;
    end else if (pop_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign pop_valid   = out_valid;
  assign pop_payload = out_data;
  assign occupancy   = {1'b0, ram_count} + {{PW{1'b0}}, out_valid};
`else
  // The RAM slot under rd_ptr cannot be overwritten while occupied, so the
  // combinational read data is stable for as long as the word is presented.
  assign pop_valid   = !ram_empty;
  assign pop_payload = ram_rd_data;
  assign pop_fire    = pop_valid && pop_ready && !flush;
  assign deq         = pop_fire;
  assign occupancy   = {1'b0, ram_count};
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Stream FIFO controller that drives an external 1-write/1-async-read distributed RAM. It owns the read/write pointers, full/empty tracking and the valid/ready handshakes on both stream sides. The RAM write port is driven from the push side, and the RAM's combinational read data is returned on the pop side. Used as the standard buffering stage in front of LSU/fetch consumers wherever a small LUT-RAM FIFO is needed.

## Interface
Parameters:
- DEPTH_LOG2, 4: log2 of RAM entry count (RAM holds 2^DEPTH_LOG2 words).
- WIDTH, 32: payload width in bits.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- push_valid  in  1  producer has a word.
- push_ready  out  1  controller accepts the word this cycle.
- push_payload  in  WIDTH  word to store.
- pop_valid  out  1  a word is presented.
- pop_ready  in  1  consumer takes the word this cycle.
- pop_payload  out  WIDTH  presented word.
- occupancy  out  DEPTH_LOG2+2  words held (RAM plus output stage).
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  DEPTH_LOG2  RAM write address.
- ram_wr_data  out  WIDTH  RAM write data.
- ram_rd_addr  out  DEPTH_LOG2  RAM read address.
- ram_rd_data  in  WIDTH  RAM combinational read data.

## Operation
- Pointers: wr_ptr and rd_ptr, each DEPTH_LOG2+1 bits. The low bits are the RAM address; the MSB is the wrap flag.
- RAM empty: wr_ptr == rd_ptr.
- RAM full: the MSBs differ and the low bits are equal.
- Push fires when push_valid && push_ready:
  - ram_wr_en=1, ram_wr_addr=wr_ptr[low], ram_wr_data=push_payload.
  - wr_ptr increments modulo 2^(DEPTH_LOG2+1).
- ram_wr_en equals the push fire exactly; it is never asserted otherwise.
- push_ready = !ram_full && !flush.
- ram_rd_addr = rd_ptr[low] at all times.
- A RAM dequeue advances rd_ptr by one.
- Simultaneous push and dequeue is legal in every non-full, non-empty state. Occupancy is then unchanged.
- When the RAM is full, push_ready=0; a same-cycle pop frees a slot for the next cycle only.
- When the RAM is empty, no dequeue occurs, and a push that cycle becomes visible the next cycle.
- flush takes priority over push and pop:
  - the next edge sets wr_ptr=rd_ptr=0 and clears the output stage;
  - ram_wr_en=0 and no pop fires during the flush cycle.
- RAM contents are never cleared; validity is purely pointer-based.
- occupancy = (wr_ptr − rd_ptr) mod 2^(DEPTH_LOG2+1), plus 1 if the output stage is present and valid.

## Timing
- Reset values:
  - wr_ptr=rd_ptr=0 and the output stage is invalid;
  - push_ready=1, pop_valid=0, occupancy=0;
  - ram_wr_en=0, ram_wr_addr=0, ram_rd_addr=0.
  - pop_payload is don't-care while pop_valid=0.
- Reset asserted mid-operation clears all state immediately (asynchronous) and drops any in-flight word.
- Push-to-pop_valid latency: 1 cycle without the output register, 2 cycles with it.
- Throughput: one push and one pop per cycle sustained.
- Handshake rules:
  - pop_payload must remain stable while pop_valid && !pop_ready.
  - pop_valid never deasserts without a pop fire, a flush or a reset.

## Configuration
- Macro: RAM_FIFO_CTRL_OUTPUT_REG_EN.
- Undefined:
  - pop_valid = !ram_empty and pop_payload = ram_rd_data (combinational path from RAM).
  - A pop fire is the RAM dequeue.
  - Capacity is 2^DEPTH_LOG2.
- Defined:
  - Adds a one-entry registered output stage. pop_valid and pop_payload come from flops.
  - The stage loads ram_rd_data and dequeues the RAM whenever the RAM is non-empty and the stage is invalid or popping this cycle.
  - Capacity is 2^DEPTH_LOG2 + 1.
  - There is no combinational path from ram_rd_data or pop_ready to pop_payload.

## Test plan
- Reset, then push 0x11,0x22,0x33 on consecutive cycles with pop_ready=0 -> occupancy reaches 3; releasing pop_ready pops 0x11,0x22,0x33 in order, one per cycle.
- DEPTH_LOG2=2, push 4 words with pop_ready=0 -> push_ready=0 and occupancy=4 (5 with the macro defined after one more push); no ram_wr_en while full.
- Continuous push and pop for 40 cycles with an incrementing payload -> no gaps after fill latency, pointers wrap, payloads arrive in strict increments.
- Full FIFO with push_valid=1 and pop_ready=1 -> a pop occurs, no write that cycle, push accepted the next cycle.
- flush asserted together with push_valid=1 and pop_ready=1 at occupancy 3 -> no write and no pop; next cycle occupancy=0, pop_valid=0, push_ready=1.
- Asynchronous reset pulse between clock edges while half full -> pop_valid=0 and occupancy=0 before the next edge; a subsequent push of 0xA5 pops as 0xA5.
